// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_pkg;

  localparam int unsigned INSTR_W        = 32;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR0  = 3'd1,
    ST_HDR1  = 3'd2,
    ST_DATA  = 3'd3,
    ST_WRITE = 3'd4,
    ST_CSUM  = 3'd5,
    ST_DONE  = 3'd6,
    ST_ERR   = 3'd7
  } state_t;

endpackage

// File: rtl/byte_word_packer.sv
// Byte lane counter and little-endian word assembly; the 4th byte is merged
// combinationally so the full word is available on the same edge it arrives.
module byte_word_packer
  import imem_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               byte_en,
  input  logic [BYTE_W-1:0]  byte_in,
  output logic [INSTR_W-1:0] word_c,
  output logic               word_ready_c
);

  localparam int unsigned IDX_W = $clog2(BYTES_PER_WORD);
  localparam int unsigned ACC_W = INSTR_W - BYTE_W;

  logic [IDX_W-1:0] idx;
  logic [ACC_W-1:0] acc;

  // Lower lanes are stored; the top lane comes straight from byte_in.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      idx <= '0;
      acc <= '0;
    end else if (byte_en) begin
      idx <= idx + IDX_W'(1);
      for (int unsigned i = 0; i < BYTES_PER_WORD - 1; i++) begin
        if (idx == IDX_W'(i)) acc[i*BYTE_W +: BYTE_W] <= byte_in;
      end
    end
  end

  assign word_ready_c = byte_en && (idx == IDX_W'(BYTES_PER_WORD - 1));
  assign word_c       = {byte_in, acc};

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed little-endian image into instruction memory and
// holds the CPU until loaded. Optional trailing XOR byte: IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DEPTH_WORDS = 64
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Start,
  input  logic [BYTE_W-1:0]  ByteIn,
  input  logic               ByteValid,
  output logic               ByteReady,
  output logic               IM_WrEn,
  output logic [ADDR_W-1:0]  IM_Addr,
  output logic [INSTR_W-1:0] IM_WrData,
  output logic               CpuHold,
  output logic               Done,
  output logic               Error
);

  localparam int unsigned CNT_W = $clog2(DEPTH_WORDS + 1);

  if (BYTES_PER_WORD * DEPTH_WORDS > (2 ** ADDR_W)) begin : g_addr_range_bad
    $error("imem_loader: DEPTH_WORDS words do not fit in ADDR_W byte address");
  end

  state_t             state, state_nxt;
  logic               accept_c, start_c, data_en_c, word_ready_c;
  logic [INSTR_W-1:0] word_c;
  logic [BYTE_W-1:0]  hdr_lo;
  logic [15:0]        n_c;
  logic [CNT_W-1:0]   remaining;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0]  csum;
`endif

  assign accept_c  = ByteValid && ByteReady;
  assign start_c   = Start && (state inside {ST_IDLE, ST_DONE, ST_ERR});
  assign data_en_c = accept_c && (state == ST_DATA);
  assign n_c       = {ByteIn, hdr_lo};

  byte_word_packer u_packer (
    .clk          (Clock),
    .rst          (Reset),
    .clear        (start_c),
    .byte_en      (data_en_c),
    .byte_in      (ByteIn),
    .word_c       (word_c),
    .word_ready_c (word_ready_c)
  );

  always_ff @(posedge Clock) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: if (Start) state_nxt = ST_HDR0;
      ST_HDR0: if (accept_c) state_nxt = ST_HDR1;
      ST_HDR1: begin
        if (accept_c) begin
          if (n_c == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_nxt = ST_CSUM;
`else
            state_nxt = ST_DONE;
`endif
          end else if (n_c > 16'(DEPTH_WORDS)) begin
            state_nxt = ST_ERR;
          end else begin
            state_nxt = ST_DATA;
          end
        end
      end
      ST_DATA: if (word_ready_c) state_nxt = ST_WRITE;
      ST_WRITE: begin
        if (remaining == CNT_W'(1)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_nxt = ST_CSUM;
`else
          state_nxt = ST_DONE;
`endif
        end else begin
          state_nxt = ST_DATA;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CSUM: if (accept_c) state_nxt = (ByteIn == csum) ? ST_DONE : ST_ERR;
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Status outputs are registered decodes of the upcoming state.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      ByteReady <= 1'b0;
      IM_WrEn   <= 1'b0;
      CpuHold   <= 1'b0;
      Done      <= 1'b0;
      Error     <= 1'b0;
    end else begin
      ByteReady <= state_nxt inside {ST_HDR0, ST_HDR1, ST_DATA, ST_CSUM};
      IM_WrEn   <= state_nxt == ST_WRITE;
      CpuHold   <= state_nxt inside {ST_HDR0, ST_HDR1, ST_DATA, ST_WRITE,
                                     ST_CSUM, ST_ERR};
      Done      <= state_nxt == ST_DONE;
      Error     <= state_nxt == ST_ERR;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      IM_Addr   <= '0;
      IM_WrData <= '0;
      hdr_lo    <= '0;
      remaining <= '0;
    end else begin
      if (start_c) IM_Addr <= '0;
      if (accept_c && state == ST_HDR0) hdr_lo <= ByteIn;
      if (accept_c && state == ST_HDR1) remaining <= CNT_W'(n_c);
      if (word_ready_c) IM_WrData <= word_c;
      if (state == ST_WRITE) begin
        IM_Addr   <= IM_Addr + ADDR_W'(BYTES_PER_WORD);
        remaining <= remaining - CNT_W'(1);
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge Clock) begin
    if (Reset || start_c) csum <= '0;
    else if (data_en_c)   csum <= csum ^ ByteIn;
  end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader; define IMEM_LOADER_CHECKSUM_EN to exercise
// the trailing checksum byte.
module tb_imem_loader;
  import imem_pkg::*;

  localparam int unsigned ADDR_W      = 8;
  localparam int unsigned DEPTH_WORDS = 64;

  logic               Clock = 1'b0;
  logic               Reset = 1'b0;
  logic               Start = 1'b0;
  logic [7:0]         ByteIn = '0;
  logic               ByteValid = 1'b0;
  logic               ByteReady, IM_WrEn, CpuHold, Done, Error;
  logic [ADDR_W-1:0]  IM_Addr;
  logic [INSTR_W-1:0] IM_WrData;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [7:0]  csum_acc;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH_WORDS(DEPTH_WORDS)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Start     (Start),
    .ByteIn    (ByteIn),
    .ByteValid (ByteValid),
    .ByteReady (ByteReady),
    .IM_WrEn   (IM_WrEn),
    .IM_Addr   (IM_Addr),
    .IM_WrData (IM_WrData),
    .CpuHold   (CpuHold),
    .Done      (Done),
    .Error     (Error)
  );

  always #5 Clock = ~Clock;

  // Capture every memory write between edges.
  always @(negedge Clock) begin
    if (IM_WrEn) begin
      wr_addr_q.push_back(32'(IM_Addr));
      wr_data_q.push_back(IM_WrData);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    csum_acc = '0;
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  // Offer one byte until accepted (bounded); returns at the negedge after transfer.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    ByteIn = b;
    ByteValid = 1'b1;
    while (!ByteReady && n < 50) begin
      @(negedge Clock);
      n++;
    end
    if (!ByteReady) check("byte_accept_timeout", 32'(ByteReady), 32'd1);
    @(negedge Clock);
    ByteValid = 1'b0;
  endtask

  task automatic send_data(input logic [7:0] b);
    csum_acc = csum_acc ^ b;
    send_byte(b);
  endtask

  task automatic finish_image();
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(csum_acc);
`endif
  endtask

  initial begin
    do_reset();
    check("rst_ready", 32'(ByteReady), 0);
    check("rst_wren", 32'(IM_WrEn), 0);
    check("rst_addr", 32'(IM_Addr), 0);
    check("rst_wrdata", IM_WrData, 0);
    check("rst_hold", 32'(CpuHold), 0);
    check("rst_done", 32'(Done), 0);
    check("rst_error", 32'(Error), 0);

    // Reset beats a simultaneous Start.
    Reset = 1'b1; Start = 1'b1;
    @(negedge Clock);
    Reset = 1'b0; Start = 1'b0;
    check("rst_start_hold", 32'(CpuHold), 0);
    check("rst_start_ready", 32'(ByteReady), 0);

    // Two-word image.
    pulse_start();
    check("t1_hold_start", 32'(CpuHold), 1);
    check("t1_ready_start", 32'(ByteReady), 1);
    send_byte(8'h02); send_byte(8'h00);
    send_data(8'h20); send_data(8'h00); send_data(8'h80); send_data(8'hD2);
    send_data(8'h41); send_data(8'h00); send_data(8'h80); send_data(8'hF8);
    finish_image();
    wait_cycles(3);
    check("t1_nwrites", wr_addr_q.size(), 2);
    if (wr_addr_q.size() == 2) begin
      check("t1_addr0", wr_addr_q[0], 32'h00);
      check("t1_data0", wr_data_q[0], 32'hD280_0020);
      check("t1_addr1", wr_addr_q[1], 32'h04);
      check("t1_data1", wr_data_q[1], 32'hF880_0041);
    end
    check("t1_done", 32'(Done), 1);
    check("t1_hold", 32'(CpuHold), 0);
    check("t1_error", 32'(Error), 0);
    check("t1_wrdata_hold", IM_WrData, 32'hF880_0041);

    // Empty image.
    pulse_start();
    check("t2_done_cleared", 32'(Done), 0);
    send_byte(8'h00); send_byte(8'h00);
    finish_image();
    wait_cycles(2);
    check("t2_done", 32'(Done), 1);
    check("t2_hold", 32'(CpuHold), 0);
    check("t2_nwrites", wr_addr_q.size(), 0);

    // Oversized image is rejected, then a good one loads.
    pulse_start();
    send_byte(8'h41); send_byte(8'h00);
    wait_cycles(2);
    check("t3_error", 32'(Error), 1);
    check("t3_hold", 32'(CpuHold), 1);
    check("t3_ready", 32'(ByteReady), 0);
    check("t3_done", 32'(Done), 0);
    check("t3_nwrites", wr_addr_q.size(), 0);
    pulse_start();
    check("t3_error_cleared", 32'(Error), 0);
    send_byte(8'h01); send_byte(8'h00);
    send_data(8'h11); send_data(8'h22); send_data(8'h33); send_data(8'h44);
    finish_image();
    wait_cycles(2);
    check("t3b_done", 32'(Done), 1);
    check("t3b_error", 32'(Error), 0);
    check("t3b_nwrites", wr_addr_q.size(), 1);
    if (wr_data_q.size() == 1) check("t3b_data", wr_data_q[0], 32'h4433_2211);

    // Gapped ByteValid during DATA.
    pulse_start();
    send_byte(8'h01); send_byte(8'h00);
    send_data(8'hAA); wait_cycles(1);
    send_data(8'hBB); wait_cycles(1);
    send_data(8'hCC); wait_cycles(1);
    send_data(8'hDD); wait_cycles(1);
    finish_image();
    wait_cycles(2);
    check("t4_nwrites", wr_addr_q.size(), 1);
    if (wr_data_q.size() == 1) begin
      check("t4_addr", wr_addr_q[0], 32'h00);
      check("t4_data", wr_data_q[0], 32'hDDCC_BBAA);
    end
    check("t4_done", 32'(Done), 1);

    // Start mid-load ignored; Reset mid-load aborts.
    pulse_start();
    send_byte(8'h03); send_byte(8'h00);
    send_data(8'h01);
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    send_data(8'h02); send_data(8'h03); send_data(8'h04);
    send_data(8'h05); send_data(8'h06);
    check("t5_hold_mid", 32'(CpuHold), 1);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    check("t5_hold", 32'(CpuHold), 0);
    check("t5_ready", 32'(ByteReady), 0);
    check("t5_addr", 32'(IM_Addr), 0);
    check("t5_done", 32'(Done), 0);
    check("t5_nwrites", wr_addr_q.size(), 1);
    if (wr_data_q.size() == 1) check("t5_data", wr_data_q[0], 32'h0403_0201);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum match then mismatch.
    pulse_start();
    send_byte(8'h01); send_byte(8'h00);
    send_data(8'h01); send_data(8'h02); send_data(8'h04); send_data(8'h08);
    send_byte(8'h0F);
    wait_cycles(2);
    check("t6_done", 32'(Done), 1);
    check("t6_error", 32'(Error), 0);
    pulse_start();
    send_byte(8'h01); send_byte(8'h00);
    send_data(8'h01); send_data(8'h02); send_data(8'h04); send_data(8'h08);
    send_byte(8'h0E);
    wait_cycles(2);
    check("t7_error", 32'(Error), 1);
    check("t7_done", 32'(Done), 0);
    check("t7_hold", 32'(CpuHold), 1);
    check("t7_nwrites", wr_addr_q.size(), 1);
    if (wr_data_q.size() == 1) begin
      check("t7_addr", wr_addr_q[0], 32'h00);
      check("t7_data", wr_data_q[0], 32'h0804_0201);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
